// File: rtl/bus_arbiter_2m_pkg.sv
// Shared types and constants for the two-master bus arbiter.
//   arb_state_t         : FSM state encoding (3 bits)
//   St*                 : state constants
//   FAULT_RDATA_DEFAULT : read data returned on a timed-out transaction
//   pick_m1()           : round-robin grant decision taken in IDLE
package bus_arbiter_2m_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t StIdle    = 3'd0;
  localparam arb_state_t StGrant0  = 3'd1;
  localparam arb_state_t StGrant1  = 3'd2;
  localparam arb_state_t StFault   = 3'd3;
  localparam arb_state_t StRelease = 3'd4;

  localparam logic [31:0] FAULT_RDATA_DEFAULT = 32'hDEADBEEF;

  // On a tie the master that did not hold the bus last wins.
  function automatic logic pick_m1(input logic req0, input logic req1, input logic last_grant);
    return req1 & (~req0 | ~last_grant);
  endfunction

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// Handshake bundle between the two masters, the arbiter and the downstream slave.
//   i_m*_rw/request/address/wdata : master -> arbiter
//   o_m*_ready/rdata              : arbiter -> master
//   o_bus_rw/request/address/wdata: arbiter -> slave
//   i_bus_ready/rdata             : slave -> arbiter
// Modport slave is the arbiter's view; modport master is the environment's view
// (both masters plus the downstream slave).
interface bus_arbiter_2m_if;

  logic        i_m0_rw;
  logic        i_m0_request;
  logic        o_m0_ready;
  logic [31:0] i_m0_address;
  logic [31:0] o_m0_rdata;
  logic [31:0] i_m0_wdata;

  logic        i_m1_rw;
  logic        i_m1_request;
  logic        o_m1_ready;
  logic [31:0] i_m1_address;
  logic [31:0] o_m1_rdata;
  logic [31:0] i_m1_wdata;

  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_bus_wdata;

  modport slave (
    input  i_m0_rw, i_m0_request, i_m0_address, i_m0_wdata,
    output o_m0_ready, o_m0_rdata,
    input  i_m1_rw, i_m1_request, i_m1_address, i_m1_wdata,
    output o_m1_ready, o_m1_rdata,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    input  i_bus_ready, i_bus_rdata
  );

  modport master (
    output i_m0_rw, i_m0_request, i_m0_address, i_m0_wdata,
    input  o_m0_ready, o_m0_rdata,
    output i_m1_rw, i_m1_request, i_m1_address, i_m1_wdata,
    input  o_m1_ready, o_m1_rdata,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
    output i_bus_ready, i_bus_rdata
  );

endinterface

// File: rtl/bus_arbiter_2m_watchdog_counter.sv
// Transaction watchdog: counts enabled cycles since the last clear.
//   i_clock, i_reset : clock, async active-low reset
//   i_clear          : zero the count (takes priority over i_enable)
//   i_enable         : count this cycle
//   o_expired        : this enabled cycle is the MAX-th since clear
// MAX = 0 leaves the counter permanently idle.
module watchdog_counter #(
  parameter int unsigned MAX = 256
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  if (MAX == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{i_clock, i_reset, i_clear, i_enable};
    assign o_expired = 1'b0;
  end else begin : g_on
    localparam int unsigned Width = $clog2(MAX + 1);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (i_clear) begin
        count_d = '0;
      end else if (i_enable) begin
        count_d = count_q + Width'(1);
      end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign o_expired = i_enable & ~i_clear & (count_q == Width'(MAX - 1));
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master, one-slave round-robin bus arbiter with a transaction watchdog.
//   i_clock, i_reset : clock, async active-low reset
//   bus              : master and slave handshakes (bus_arbiter_2m_if.slave)
//   o_fault          : one-cycle pulse when a transaction times out
//   o_fault_address  : address of the last timed-out transaction
//   o_fault_count    : number of timeouts, saturating at 255
// The grant is held for a whole transaction; every transaction ends with one
// RELEASE cycle so the slave always sees request low between transactions.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 256,
  parameter logic [31:0] FAULT_RDATA = FAULT_RDATA_DEFAULT
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  bus_arbiter_2m_if.slave        bus,
  output logic                   o_fault,
  output logic [31:0]            o_fault_address,
  output logic [7:0]             o_fault_count
);

  arb_state_t  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [7:0]  fault_count_q, fault_count_d;

  logic        in_grant, wd_expired;
  logic        sel_m1, sel_req, sel_rw;
  logic [31:0] sel_addr, sel_wdata;
  logic        ready_sel;
  logic [31:0] rdata_sel;
  logic        bus_rw, bus_request;
  logic [31:0] bus_address, bus_wdata;

  assign in_grant = (state_q == StGrant0) || (state_q == StGrant1);

  watchdog_counter #(
    .MAX (TIMEOUT)
  ) u_watchdog (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (~in_grant),
    .i_enable  (in_grant & ~bus.i_bus_ready),
    .o_expired (wd_expired)
  );

  // last_grant always names the master owning GRANT/FAULT, so it selects the fields.
  assign sel_m1    = last_grant_q;
  assign sel_req   = sel_m1 ? bus.i_m1_request : bus.i_m0_request;
  assign sel_rw    = sel_m1 ? bus.i_m1_rw      : bus.i_m0_rw;
  assign sel_addr  = sel_m1 ? bus.i_m1_address : bus.i_m0_address;
  assign sel_wdata = sel_m1 ? bus.i_m1_wdata   : bus.i_m0_wdata;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    fault_d       = 1'b0;
    fault_addr_d  = fault_addr_q;
    fault_count_d = fault_count_q;
    bus_rw        = 1'b0;
    bus_request   = 1'b0;
    bus_address   = '0;
    bus_wdata     = '0;
    ready_sel     = 1'b0;
    rdata_sel     = '0;

    case (state_q)
      StIdle: begin
        if (bus.i_m0_request || bus.i_m1_request) begin
          if (pick_m1(bus.i_m0_request, bus.i_m1_request, last_grant_q)) begin
            state_d      = StGrant1;
            last_grant_d = 1'b1;
          end else begin
            state_d      = StGrant0;
            last_grant_d = 1'b0;
          end
        end
      end
      StGrant0, StGrant1: begin
        bus_rw      = sel_rw;
        bus_request = sel_req;
        bus_address = sel_addr;
        bus_wdata   = sel_wdata;
        ready_sel   = bus.i_bus_ready;
        rdata_sel   = bus.i_bus_rdata;
        // A dropped request ends the transaction even if the watchdog fires now.
        if (!sel_req) begin
          state_d = StRelease;
        end else if (wd_expired) begin
          state_d       = StFault;
          fault_d       = 1'b1;
          fault_addr_d  = sel_addr;
          fault_count_d = (fault_count_q == 8'hFF) ? fault_count_q : fault_count_q + 8'd1;
        end
      end
      StFault: begin
        ready_sel = 1'b1;
        rdata_sel = FAULT_RDATA;
        if (!sel_req) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign bus.o_bus_rw      = bus_rw;
  assign bus.o_bus_request = bus_request;
  assign bus.o_bus_address = bus_address;
  assign bus.o_bus_wdata   = bus_wdata;
  assign bus.o_m0_ready    = ready_sel & ~sel_m1;
  assign bus.o_m1_ready    = ready_sel & sel_m1;
  assign bus.o_m0_rdata    = rdata_sel & {32{~sel_m1}};
  assign bus.o_m1_rdata    = rdata_sel & {32{sel_m1}};

  assign o_fault         = fault_q;
  assign o_fault_address = fault_addr_q;
  assign o_fault_count   = fault_count_q;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
module tb_bus_arbiter_2m;

  logic        i_clock;
  logic        i_reset;
  logic        o_fault;
  logic [31:0] o_fault_address;
  logic [7:0]  o_fault_count;
  int          checks;
  int          errors;

  bus_arbiter_2m_if bif ();

  bus_arbiter_2m #(
    .TIMEOUT     (8),
    .FAULT_RDATA (32'hDEADBEEF)
  ) u_dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .bus             (bif),
    .o_fault         (o_fault),
    .o_fault_address (o_fault_address),
    .o_fault_count   (o_fault_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic next();
    @(negedge i_clock);
  endtask

  task automatic clear_inputs();
    bif.i_m0_rw = 1'b0; bif.i_m0_request = 1'b0; bif.i_m0_address = '0; bif.i_m0_wdata = '0;
    bif.i_m1_rw = 1'b0; bif.i_m1_request = 1'b0; bif.i_m1_address = '0; bif.i_m1_wdata = '0;
    bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b0;
    #1;
    checks++;
    if ({bif.o_bus_request, bif.o_m0_ready, bif.o_m1_ready, o_fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000",
               {bif.o_bus_request, bif.o_m0_ready, bif.o_m1_ready, o_fault});
    end
    next();
    i_reset = 1'b1;
    next();
    #1;
    checks++;
    if ({o_fault_address, o_fault_count} !== 40'h0) begin
      errors++;
      $display("FAIL reset_fault_regs got %h/%h exp 0/0", o_fault_address, o_fault_count);
    end
  endtask

  task automatic test_single_read();
    next();
    bif.i_m0_address = 32'h100; bif.i_m0_request = 1'b1;
    #1;
    checks++;
    if (bif.o_bus_request !== 1'b0) begin
      errors++; $display("FAIL t1_grant_latency got %b exp 0", bif.o_bus_request);
    end
    next(); #1;
    checks++;
    if ({bif.o_bus_request, bif.o_bus_rw, bif.o_bus_address} !== {2'b10, 32'h100}) begin
      errors++;
      $display("FAIL t1_bus_fields got %b%b %h exp 10 00000100",
               bif.o_bus_request, bif.o_bus_rw, bif.o_bus_address);
    end
    next(); #1;
    checks++;
    if (bif.o_m0_ready !== 1'b0) begin
      errors++; $display("FAIL t1_ready_early got %b exp 0", bif.o_m0_ready);
    end
    next();
    bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h12345678;
    #1;
    checks++;
    if ({bif.o_m0_ready, bif.o_m0_rdata} !== {1'b1, 32'h12345678}) begin
      errors++;
      $display("FAIL t1_read_data got %b %h exp 1 12345678", bif.o_m0_ready, bif.o_m0_rdata);
    end
    next();
    bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
    next(); #1;
    checks++;
    if ({bif.o_bus_request, bif.o_m0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL t1_release got %b%b exp 00", bif.o_bus_request, bif.o_m0_ready);
    end
    next();
  endtask

  task automatic test_round_robin();
    i_reset = 1'b0;
    #1;
    next();
    i_reset = 1'b1;
    next();
    bif.i_m0_address = 32'h110; bif.i_m0_request = 1'b1;
    bif.i_m1_address = 32'h210; bif.i_m1_request = 1'b1;
    next();
    bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'hA0A0A0A0;
    #1;
    checks++;
    if ({bif.o_bus_address, bif.o_m0_ready, bif.o_m1_ready, bif.o_m0_rdata, bif.o_m1_rdata} !==
        {32'h110, 2'b10, 32'hA0A0A0A0, 32'h0}) begin
      errors++;
      $display("FAIL t2_tie_m0_first got %h %b%b %h %h exp 00000110 10 a0a0a0a0 00000000",
               bif.o_bus_address, bif.o_m0_ready, bif.o_m1_ready, bif.o_m0_rdata, bif.o_m1_rdata);
    end
    next();
    bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0;
    next();
    bif.i_m0_address = 32'h114; bif.i_m0_request = 1'b1;
    #1;
    checks++;
    if (bif.o_bus_request !== 1'b0) begin
      errors++; $display("FAIL t2_release got %b exp 0", bif.o_bus_request);
    end
    next(); #1;
    checks++;
    if (bif.o_bus_request !== 1'b0) begin
      errors++; $display("FAIL t2_idle_gap got %b exp 0", bif.o_bus_request);
    end
    next();
    bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'hB1B1B1B1;
    #1;
    checks++;
    if ({bif.o_bus_address, bif.o_m1_ready, bif.o_m0_ready, bif.o_m1_rdata} !==
        {32'h210, 2'b10, 32'hB1B1B1B1}) begin
      errors++;
      $display("FAIL t2_tie_m1_next got %h %b%b %h exp 00000210 10 b1b1b1b1",
               bif.o_bus_address, bif.o_m1_ready, bif.o_m0_ready, bif.o_m1_rdata);
    end
    next();
    bif.i_m1_request = 1'b0; bif.i_bus_ready = 1'b0;
    next();
    next();
    next();
    bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'hC2C2C2C2;
    #1;
    checks++;
    if ({bif.o_bus_address, bif.o_m0_ready, bif.o_m0_rdata} !== {32'h114, 1'b1, 32'hC2C2C2C2}) begin
      errors++;
      $display("FAIL t2_m0_after_m1 got %h %b %h exp 00000114 1 c2c2c2c2",
               bif.o_bus_address, bif.o_m0_ready, bif.o_m0_rdata);
    end
    next();
    bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0;
    next();
    next();
  endtask

  task automatic test_write_contention();
    next();
    bif.i_m1_rw = 1'b1; bif.i_m1_address = 32'h200; bif.i_m1_wdata = 32'hCAFEF00D;
    bif.i_m1_request = 1'b1;
    next(); #1;
    checks++;
    if ({bif.o_bus_rw, bif.o_bus_address, bif.o_bus_wdata} !== {1'b1, 32'h200, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL t3_write_fields got %b %h %h exp 1 00000200 cafef00d",
               bif.o_bus_rw, bif.o_bus_address, bif.o_bus_wdata);
    end
    bif.i_m0_address = 32'h204; bif.i_m0_request = 1'b1;
    #1;
    checks++;
    if ({bif.o_m0_ready, bif.o_bus_address} !== {1'b0, 32'h200}) begin
      errors++;
      $display("FAIL t3_m0_waits got %b %h exp 0 00000200", bif.o_m0_ready, bif.o_bus_address);
    end
    next();
    bif.i_bus_ready = 1'b1;
    #1;
    checks++;
    if ({bif.o_m1_ready, bif.o_m0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t3_m1_done got %b%b exp 10", bif.o_m1_ready, bif.o_m0_ready);
    end
    next();
    bif.i_m1_request = 1'b0; bif.i_m1_rw = 1'b0; bif.i_bus_ready = 1'b0;
    next(); #1;
    checks++;
    if ({bif.o_m0_ready, bif.o_bus_request} !== 2'b00) begin
      errors++;
      $display("FAIL t3_release got %b%b exp 00", bif.o_m0_ready, bif.o_bus_request);
    end
    next();
    next(); #1;
    checks++;
    if ({bif.o_bus_request, bif.o_bus_rw, bif.o_bus_address} !== {2'b10, 32'h204}) begin
      errors++;
      $display("FAIL t3_m0_granted got %b%b %h exp 10 00000204",
               bif.o_bus_request, bif.o_bus_rw, bif.o_bus_address);
    end
    bif.i_bus_ready = 1'b1;
    next();
    bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0;
    next();
    next();
  endtask

  task automatic test_timeout();
    next();
    bif.i_m0_address = 32'h300; bif.i_m0_request = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      next(); #1;
      checks++;
      if ({bif.o_bus_request, bif.o_m0_ready, o_fault} !== 3'b100) begin
        errors++;
        $display("FAIL t4_wait_cycle%0d got %b%b%b exp 100", i,
                 bif.o_bus_request, bif.o_m0_ready, o_fault);
      end
    end
    next(); #1;
    checks++;
    if ({o_fault, bif.o_m0_ready, bif.o_bus_request, bif.o_m1_ready} !== 4'b1100 ||
        bif.o_m0_rdata !== 32'hDEADBEEF || bif.o_m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL t4_fault_entry got %b%b%b%b %h %h exp 1100 deadbeef 00000000",
               o_fault, bif.o_m0_ready, bif.o_bus_request, bif.o_m1_ready,
               bif.o_m0_rdata, bif.o_m1_rdata);
    end
    checks++;
    if ({o_fault_address, o_fault_count} !== {32'h300, 8'd1}) begin
      errors++;
      $display("FAIL t4_fault_regs got %h %0d exp 00000300 1", o_fault_address, o_fault_count);
    end
    next(); #1;
    checks++;
    if ({o_fault, bif.o_m0_ready} !== 2'b01) begin
      errors++; $display("FAIL t4_fault_pulse got %b%b exp 01", o_fault, bif.o_m0_ready);
    end
    bif.i_m0_request = 1'b0;
    next(); #1;
    checks++;
    if (bif.o_m0_ready !== 1'b0) begin
      errors++; $display("FAIL t4_release got %b exp 0", bif.o_m0_ready);
    end
    next();
  endtask

  task automatic test_ready_on_deadline();
    next();
    bif.i_m0_address = 32'h304; bif.i_m0_request = 1'b1;
    for (int i = 1; i <= 7; i++) next();
    next();
    bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h5555AAAA;
    #1;
    checks++;
    if ({bif.o_m0_ready, bif.o_m0_rdata} !== {1'b1, 32'h5555AAAA}) begin
      errors++;
      $display("FAIL t5_ready_wins got %b %h exp 1 5555aaaa", bif.o_m0_ready, bif.o_m0_rdata);
    end
    next();
    bif.i_m0_request = 1'b0; bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
    #1;
    checks++;
    if (o_fault !== 1'b0) begin
      errors++; $display("FAIL t5_no_fault got %b exp 0", o_fault);
    end
    next(); #1;
    checks++;
    if ({o_fault, bif.o_bus_request, bif.o_m0_ready, o_fault_count, o_fault_address} !==
        {3'b000, 8'd1, 32'h300}) begin
      errors++;
      $display("FAIL t5_counters got %b%b%b %0d %h exp 000 1 00000300",
               o_fault, bif.o_bus_request, bif.o_m0_ready, o_fault_count, o_fault_address);
    end
    next();
  endtask

  task automatic test_async_reset();
    next();
    bif.i_m1_address = 32'h400; bif.i_m1_request = 1'b1;
    next(); #1;
    checks++;
    if ({bif.o_bus_request, bif.o_bus_address} !== {1'b1, 32'h400}) begin
      errors++;
      $display("FAIL t6_grant1 got %b %h exp 1 00000400", bif.o_bus_request, bif.o_bus_address);
    end
    #2;
    i_reset = 1'b0;
    #1;
    checks++;
    if ({bif.o_bus_request, bif.o_m1_ready, bif.o_bus_address} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL t6_async_drop got %b%b %h exp 00 00000000",
               bif.o_bus_request, bif.o_m1_ready, bif.o_bus_address);
    end
    checks++;
    if ({o_fault_count, o_fault_address} !== 40'h0) begin
      errors++;
      $display("FAIL t6_fault_regs_cleared got %0d %h exp 0 0", o_fault_count, o_fault_address);
    end
    bif.i_m1_request = 1'b0;
    next();
    i_reset = 1'b1;
    next();
    bif.i_m0_address = 32'h500; bif.i_m0_request = 1'b1;
    bif.i_m1_address = 32'h600; bif.i_m1_request = 1'b1;
    next(); #1;
    checks++;
    if ({bif.o_bus_request, bif.o_bus_address} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL t6_tie_after_reset got %b %h exp 1 00000500",
               bif.o_bus_request, bif.o_bus_address);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_contention();
    test_timeout();
    test_ready_on_deadline();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
